// File: rtl/memory.sv
// 32 x 8 single-port program/data memory for the simple RISC processor.
// Synchronous write, registered read, asynchronous clear of the whole array.
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Flip-flop storage so that every word clears on reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write has priority. A simultaneous read is dropped, and data_out holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else begin
            if (wr) begin
                mem[addr] <= data_in;
            end else if (rd) begin
                data_out <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for the 32 x 8 memory.
module tb_memory;

    logic       clk;
    logic       rst;
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int vectors     = 0;
    int miscompares = 0;

    memory #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .DEPTH(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] expected);
        vectors++;
        assert (data_out === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, expected);
        end
    endtask

    initial begin
        rst     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 5'h00;
        data_in = 8'h00;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 8'h00);
        @(negedge clk);
        rst = 1'b1;

        step(1'b1, 1'b0, 5'h05, 8'h00);
        check("read_05_after_reset", 8'h00);

        // Writes: A5 to 05, then LDA 10 (8'hAA) to 0A.
        step(1'b0, 1'b1, 5'h05, 8'hA5);
        check("write_no_dout_change", 8'h00);
        step(1'b0, 1'b1, 5'h0A, 8'hAA);

        step(1'b1, 1'b0, 5'h05, 8'h00);
        check("read_05", 8'hA5);
        step(1'b1, 1'b0, 5'h0A, 8'h00);
        check("read_0A", 8'hAA);
        step(1'b1, 1'b0, 5'h0F, 8'h00);
        check("read_unwritten_0F", 8'h00);

        // Write priority: rd=wr=1 writes and leaves data_out alone.
        step(1'b1, 1'b1, 5'h15, 8'h55);
        check("rdwr_holds_dout", 8'h00);
        step(1'b1, 1'b0, 5'h15, 8'h00);
        check("read_15_after_rdwr", 8'h55);

        // Hold with rd=0 while addr and data_in move around.
        step(1'b1, 1'b0, 5'h05, 8'h00);
        check("read_05_before_hold", 8'hA5);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 5'(i * 7 + 3), 8'(8'h30 + i));
            check($sformatf("hold_%0d", i), 8'hA5);
        end
        step(1'b1, 1'b0, 5'h0A, 8'h00);
        check("read_0A_after_hold", 8'hAA);
        step(1'b1, 1'b0, 5'h05, 8'h00);
        check("read_05_after_hold", 8'hA5);
        step(1'b1, 1'b0, 5'h03, 8'h00);
        check("read_03_untouched", 8'h00);

        // Top address, then asynchronous reset between edges.
        step(1'b0, 1'b1, 5'h1F, 8'hFF);
        step(1'b1, 1'b0, 5'h1F, 8'h00);
        check("read_1F", 8'hFF);
        rd = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_dout", 8'h00);
        #1;
        rst = 1'b1;
        @(negedge clk);

        step(1'b1, 1'b0, 5'h1F, 8'h00);
        check("read_1F_after_reset", 8'h00);
        step(1'b1, 1'b0, 5'h05, 8'h00);
        check("read_05_after_reset2", 8'h00);
        step(1'b1, 1'b0, 5'h15, 8'h00);
        check("read_15_after_reset2", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
